// File: rtl/stopwatch_ctrl.sv
// Four-digit BCD stopwatch: IDLE/RUN/PAUSE/OVF control FSM with a DIV-cycle prescaler.
// All outputs are registered; the command priority is clear > stop > start.
module stopwatch_ctrl #(
   parameter int unsigned DIV = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   output logic [15:0] count,
   output logic        running,
   output logic        overflow
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      OVF
   } state_t;

   localparam logic [15:0] LP_PRESC_LAST = 16'(DIV - 1);
   localparam logic [15:0] LP_COUNT_MAX  = 16'h9999;

   state_t      r_state;
   state_t      w_state_nx;
   logic [15:0] r_presc;
   logic [15:0] w_presc_nx;
   logic [15:0] r_count;
   logic [15:0] w_count_nx;
   logic [15:0] w_count_inc;
   logic        r_ovf;
   logic        w_ovf_nx;
   logic        r_running;
   logic        w_wrap;
   logic        w_carry;

   // BCD increment: a carry ripples through every digit in one cycle
   always_comb begin
      w_count_inc = r_count;
      w_carry     = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         if (w_carry) begin
            if (r_count[4*i +: 4] == 4'd9) begin
               w_count_inc[4*i +: 4] = 4'd0;
            end else begin
               w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
               w_carry               = 1'b0;
            end
         end
      end
   end

   assign w_wrap = (r_presc == LP_PRESC_LAST);

   always_comb begin
      w_state_nx = r_state;
      w_presc_nx = r_presc;
      w_count_nx = r_count;
      w_ovf_nx   = r_ovf;
      if (clear) begin
         w_state_nx = IDLE;
         w_presc_nx = '0;
         w_count_nx = '0;
         w_ovf_nx   = 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (!stop && start) begin
                  w_state_nx = RUN;
                  w_presc_nx = '0;
               end
            end
            RUN: begin
               if (stop) begin
                  w_state_nx = PAUSE;
               end else if (w_wrap) begin
                  w_presc_nx = '0;
                  if (r_count == LP_COUNT_MAX) begin
                     w_state_nx = OVF;
                     w_ovf_nx   = 1'b1;
                  end else begin
                     w_count_nx = w_count_inc;
                  end
               end else begin
                  w_presc_nx = r_presc + 16'd1;
               end
            end
            PAUSE: begin
               // resume keeps the prescaler phase reached before the pause
               if (!stop && start) begin
                  w_state_nx = RUN;
               end
            end
            OVF: begin
            end
            default: begin
               w_state_nx = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_presc   <= '0;
         r_count   <= '0;
         r_ovf     <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_presc   <= w_presc_nx;
         r_count   <= w_count_nx;
         r_ovf     <= w_ovf_nx;
         r_running <= (w_state_nx == RUN);
      end
   end

   assign count    = r_count;
   assign running  = r_running;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: three instances (DIV=1, 3, 4) driven with directed
// sequences; expected outputs are queued after each edge and checked by a negedge monitor.
module tb_stopwatch_ctrl;

   logic        clk;
   logic [2:0]  reset_v;
   logic [2:0]  start_v;
   logic [2:0]  stop_v;
   logic [2:0]  clear_v;
   logic [15:0] count_v [3];
   logic [2:0]  running_v;
   logic [2:0]  overflow_v;

   int n_tests;
   int n_fail;

   typedef struct {
      string       name;
      int unsigned inst;
      logic [15:0] cnt;
      logic        run;
      logic        ovf;
   } exp_t;

   exp_t exp_q[$];

   stopwatch_ctrl #(.DIV(1)) u_div1 (
      .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .stop(stop_v[0]), .clear(clear_v[0]),
      .count(count_v[0]), .running(running_v[0]), .overflow(overflow_v[0])
   );

   stopwatch_ctrl #(.DIV(3)) u_div3 (
      .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .stop(stop_v[1]), .clear(clear_v[1]),
      .count(count_v[1]), .running(running_v[1]), .overflow(overflow_v[1])
   );

   stopwatch_ctrl #(.DIV(4)) u_div4 (
      .clk(clk), .reset(reset_v[2]), .start(start_v[2]), .stop(stop_v[2]), .clear(clear_v[2]),
      .count(count_v[2]), .running(running_v[2]), .overflow(overflow_v[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int unsigned n);
      logic [15:0] b;
      b[3:0]   = 4'(n % 10);
      b[7:4]   = 4'((n / 10) % 10);
      b[11:8]  = 4'((n / 100) % 10);
      b[15:12] = 4'((n / 1000) % 10);
      return b;
   endfunction

   task automatic drive(input int unsigned i, input logic rst, input logic st,
                        input logic sp, input logic cl);
      reset_v[i] = rst;
      start_v[i] = st;
      stop_v[i]  = sp;
      clear_v[i] = cl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input int unsigned i, input string name, input int unsigned n,
                             input logic run, input logic ovf);
      exp_t e;
      e.name = name;
      e.inst = i;
      e.cnt  = to_bcd(n);
      e.run  = run;
      e.ovf  = ovf;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_tests++;
         if (count_v[e.inst] !== e.cnt || running_v[e.inst] !== e.run ||
             overflow_v[e.inst] !== e.ovf) begin
            n_fail++;
            $display("FAIL %s (DIV inst %0d): got count=%h running=%b overflow=%b, want count=%h running=%b overflow=%b",
                     e.name, e.inst, count_v[e.inst], running_v[e.inst], overflow_v[e.inst],
                     e.cnt, e.run, e.ovf);
         end
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset_v = '0;
      start_v = '1;
      stop_v  = '0;
      clear_v = '0;

      // reset held two cycles with start asserted
      repeat (2) begin
         tick();
         for (int unsigned i = 0; i < 3; i++) expect_out(i, "reset_hold", 0, 1'b0, 1'b0);
      end
      drive(1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(2, 1'b1, 1'b0, 1'b0, 1'b0);

      // DIV=1: start, count all the way to overflow
      drive(0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out(0, "start_latency", 0, 1'b1, 1'b0);
      expect_out(1, "idle_after_reset", 0, 1'b0, 1'b0);
      expect_out(2, "idle_after_reset", 0, 1'b0, 1'b0);
      drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int unsigned j = 1; j <= 9999; j++) begin
         tick();
         expect_out(0, "count_div1", j, 1'b1, 1'b0);
      end
      tick();
      expect_out(0, "overflow_set", 9999, 1'b0, 1'b1);
      drive(0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out(0, "ovf_ignores_start", 9999, 1'b0, 1'b1);
      drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out(0, "ovf_ignores_stop", 9999, 1'b0, 1'b1);
      drive(0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      expect_out(0, "ovf_clear", 0, 1'b0, 1'b0);

      // priorities
      drive(0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      expect_out(0, "idle_stop_beats_start", 0, 1'b0, 1'b0);
      drive(0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out(0, "idle_start", 0, 1'b1, 1'b0);
      drive(0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      expect_out(0, "run_stop_beats_start", 0, 1'b0, 1'b0);
      drive(0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      expect_out(0, "pause_clear", 0, 1'b0, 1'b0);

      drive(0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out(0, "restart", 0, 1'b1, 1'b0);
      drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int unsigned j = 1; j <= 345; j++) begin
         tick();
         expect_out(0, "count_to_0345", j, 1'b1, 1'b0);
      end
      drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out(0, "pause_0345", 345, 1'b0, 1'b0);
      drive(0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      expect_out(0, "clear_beats_start", 0, 1'b0, 1'b0);

      drive(0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out(0, "restart2", 0, 1'b1, 1'b0);
      drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int unsigned j = 1; j <= 345; j++) begin
         tick();
         expect_out(0, "count_to_0345b", j, 1'b1, 1'b0);
      end
      drive(0, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      expect_out(0, "reset_beats_cmds", 0, 1'b0, 1'b0);
      drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      expect_out(0, "idle_after_reset_run", 0, 1'b0, 1'b0);

      // DIV=3: first increment three edges after start
      drive(1, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out(1, "div3_start", 0, 1'b1, 1'b0);
      drive(1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int unsigned j = 1; j <= 6; j++) begin
         tick();
         expect_out(1, "div3_count", j / 3, 1'b1, 1'b0);
      end
      drive(1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out(1, "div3_stop", 2, 1'b0, 1'b0);
      drive(1, 1'b1, 1'b0, 1'b0, 1'b0);

      // DIV=4: pause with prescaler at 2, resume keeps the phase
      drive(2, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out(2, "div4_start", 0, 1'b1, 1'b0);
      drive(2, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int unsigned j = 1; j <= 22; j++) begin
         tick();
         expect_out(2, "div4_count", j / 4, 1'b1, 1'b0);
      end
      drive(2, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out(2, "div4_stop", 5, 1'b0, 1'b0);
      drive(2, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (20) begin
         tick();
         expect_out(2, "div4_paused_hold", 5, 1'b0, 1'b0);
      end
      drive(2, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out(2, "div4_resume", 5, 1'b1, 1'b0);
      drive(2, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      expect_out(2, "div4_resume_p3", 5, 1'b1, 1'b0);
      tick();
      expect_out(2, "div4_resume_step", 6, 1'b1, 1'b0);
      repeat (3) begin
         tick();
         expect_out(2, "div4_run_to_p3", 6, 1'b1, 1'b0);
      end
      drive(2, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out(2, "div4_stop_on_wrap", 6, 1'b0, 1'b0);
      drive(2, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out(2, "div4_resume_at_p3", 6, 1'b1, 1'b0);
      drive(2, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      expect_out(2, "div4_deferred_step", 7, 1'b1, 1'b0);
      repeat (2) begin
         tick();
         expect_out(2, "div4_run_to_p2", 7, 1'b1, 1'b0);
      end
      drive(2, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      expect_out(2, "div4_reset_mid_run", 0, 1'b0, 1'b0);
      drive(2, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out(2, "div4_start_after_reset", 0, 1'b1, 1'b0);
      drive(2, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) begin
         tick();
         expect_out(2, "div4_no_partial_step", 0, 1'b1, 1'b0);
      end
      tick();
      expect_out(2, "div4_full_period_step", 1, 1'b1, 1'b0);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DIV, default 10: clk cycles per count step; legal range 1..65535.
REQ-002 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port reset  input  1  synchronous, active-low reset; sampled only on the clk rising edge.
REQ-004 Port start  input  1  level-sampled command: begin or resume counting.
REQ-005 Port stop  input  1  level-sampled command: pause counting.
REQ-006 Port clear  input  1  level-sampled command: return to zero and idle.
REQ-007 Port count  output  16  four BCD digits {d3,d2,d1,d0}; d0 least significant; registered.
REQ-008 Port running  output  1  1 exactly while the FSM is in RUN; registered.
REQ-009 Port overflow  output  1  sticky flag, set when a step is requested at 9999; registered.

Function
REQ-010 FSM states SHALL be IDLE, RUN, PAUSE and OVF.
REQ-011 Command priority per cycle SHALL be clear > stop > start.
- Lower-priority commands in the same cycle are ignored.
REQ-012 clear SHALL, from any state, take effect at the next edge:
- FSM -> IDLE; count -> 0000; prescaler -> 0; overflow -> 0.
REQ-013 stop SHALL move RUN -> PAUSE.
- stop in IDLE, PAUSE or OVF: no effect.
REQ-014 start SHALL move IDLE -> RUN with prescaler cleared to 0.
REQ-015 start SHALL move PAUSE -> RUN with prescaler value preserved.
REQ-016 start in RUN or OVF: no effect.
REQ-017 Prescaler SHALL advance only on edges where the FSM is already in RUN and neither clear nor stop is asserted.
- In PAUSE and OVF, prescaler and count hold.
REQ-018 When the prescaler is DIV-1 at an advancing edge, it SHALL wrap to 0 and one count step SHALL occur at that same edge.
- DIV=1: one step every advancing edge.
REQ-019 Latency: start sampled at edge k from IDLE SHALL give running=1 after edge k.
- First increment is visible after edge k+DIV.
REQ-020 Step rule: d0 increments.
- A digit at 9 wraps to 0 and carries +1 into the next digit; carries ripple within the same edge.
- Digits SHALL never hold values 10..15.
REQ-021 A step requested while count = 9999 SHALL leave count at 9999.
- At that edge, overflow -> 1 and FSM -> OVF (running -> 0).
REQ-022 OVF SHALL be left only via clear or reset.
REQ-023 A stop asserted on an edge where the prescaler would wrap SHALL suppress that step.
- Count and prescaler hold.
REQ-024 All outputs SHALL be driven from registers; no combinational input-to-output path.

Reset
REQ-025 With reset=0 at a clk edge, the following SHALL take effect after that edge, regardless of state or other inputs:
- FSM = IDLE; count = 0000; prescaler = 0; running = 0; overflow = 0.
REQ-026 reset=0 SHALL override clear, stop and start in the same cycle.
REQ-027 Reset asserted mid-RUN SHALL discard the count and prescaler.
- No partial step is retained.

Verification
REQ-028 Reset: reset=0 for 2 cycles with start=1 held -> count=0000, running=0, overflow=0. reset=1 then start pulse -> running=1 next edge.
REQ-029 Counting, DIV=1: start pulse at edge k, 12 further cycles -> count=0012 after edge k+12. DIV=3: first increment after edge k+3.
REQ-030 Carry: run from 0099, one step -> 0100. From 0999, one step -> 1000. No digit ever exceeds 9.
REQ-031 Pause/resume, DIV=4: stop when prescaler=2 at count 0005 -> running=0; count stays 0005 for 20 cycles. start -> running=1; next step after 2 advancing edges -> 0006.
REQ-032 Overflow, DIV=1: run to 9999, one more cycle -> count=9999, overflow=1, running=0. start ignored. clear -> 0000, overflow=0, IDLE.
REQ-033 Priorities: start+stop in IDLE -> stays IDLE. stop+start in RUN -> PAUSE. clear+start in PAUSE at 0345 -> 0000, IDLE. reset=0 in RUN at 0345 -> 0000, IDLE next edge.
